// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and parameter defaults.
package period_meter_pkg;

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } pm_state_e;

  localparam int unsigned PM_CNT_W   = 32;
  localparam int unsigned PM_TIMEOUT = 100_000_000;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a one-flop edge detector.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Edges are flagged combinationally so the FSM reacts on the third clock after d moves.
  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles,
// with a valid/ack result handshake plus sticky timeout and overrun flags.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = PM_CNT_W,
  parameter int unsigned TIMEOUT = PM_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             overrun
);

  // TIMEOUT must stay below 2^CNT_W so cnt reaches this value before it could wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;
  logic             ovr_q, ovr_d;
  logic             rise, fall;
  logic             load;
  logic             ack_s;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign load  = (state_q == MEASURE) && rise;
  assign ack_s = meas_ack && valid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_cap_d = hi_cap_q;
    to_d     = to_q;
    case (state_q)
      ARM: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d = ARM;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          if (fall) hi_cap_d = cnt_q;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARM;
    endcase
    if (load) to_d = 1'b0;
  end

  // A load wins over an acknowledge in the same cycle; an ack still consumes the old result.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (load) begin
      period_d = cnt_q;
      high_d   = hi_cap_q;
      valid_d  = 1'b1;
      if (valid_q && !meas_ack) ovr_d = 1'b1;
    end else if (ack_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      hi_cap_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_cap_q <= hi_cap_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      to_q     <= to_d;
      ovr_q    <= ovr_d;
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign timeout    = to_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus random waveforms against a timestamp model.
module tb_period_meter;

  localparam int TO = 100;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_ack = 1'b0;
  logic        meas_valid, timeout, overrun;
  logic [31:0] period, high_time;
  logic        l_valid, l_to, l_ovr;
  logic [31:0] l_period, l_high;

  always #5 clk_in = ~clk_in;

  period_meter #(.CNT_W(32), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .meas_ack(meas_ack),
    .meas_valid(meas_valid), .period(period), .high_time(high_time),
    .timeout(timeout), .overrun(overrun)
  );

  period_meter #(.CNT_W(32), .TIMEOUT(1000)) dut_l (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .meas_ack(meas_ack),
    .meas_valid(l_valid), .period(l_period), .high_time(l_high),
    .timeout(l_to), .overrun(l_ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ncall = 0;

  // Reference model: timestamps of detected edges, not cycle counters.
  int          t;
  logic        q[$];
  bit          m_arm, m_valid, m_to, m_ovr;
  int          m_t_rise, m_hi;
  logic [31:0] m_period, m_high;

  task automatic model_reset();
    q.delete();
    repeat (4) q.push_back(1'b0);
    t = 0; m_arm = 0; m_valid = 0; m_to = 0; m_ovr = 0;
    m_t_rise = 0; m_hi = 0; m_period = '0; m_high = '0;
  endtask

  task automatic model_step(input logic s, input logic a);
    logic r, f;
    t++;
    q.push_back(s);
    void'(q.pop_front());
    r = q[1] & ~q[0];
    f = ~q[1] & q[0];
    if (r && m_arm) begin
      m_period = 32'(t - m_t_rise);
      m_high   = 32'(m_hi);
      m_to     = 0;
      if (m_valid && !a) m_ovr = 1;
      m_valid  = 1;
      m_t_rise = t;
    end else begin
      if (a && m_valid) begin m_valid = 0; m_ovr = 0; end
      if (r) begin
        m_arm = 1; m_t_rise = t;
      end else if (m_arm && (t - m_t_rise == TO - 1)) begin
        m_arm = 0; m_to = 1;
      end else if (m_arm && f) begin
        m_hi = t - m_t_rise;
      end
    end
  endtask

  function automatic logic [66:0] obs_v();
    return {meas_valid, timeout, overrun, period, high_time};
  endfunction

  function automatic logic [66:0] exp_v();
    return {m_valid, m_to, m_ovr, m_period, m_high};
  endfunction

  // Called at a negedge; drives inputs, advances one clock, returns at the next negedge.
  task automatic cyc(input logic s, input logic a);
    sig_in = s;
    meas_ack = a;
    @(posedge clk_in);
    model_step(s, a);
    ncall++;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    meas_ack = 1'b0;
    repeat (2) @(negedge clk_in);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    sig_in = 1'b1;
    #1;
    n_cmp++;
    if (obs_v() !== 67'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", obs_v());
    end
    n_cmp++;
    if ({l_valid, l_to, l_ovr, l_period, l_high} !== 67'd0) begin
      n_bad++; $display("FAIL reset_outputs_l: got %h want 0", {l_valid, l_to, l_ovr, l_period, l_high});
    end
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if (obs_v() !== 67'd0) begin
      n_bad++; $display("FAIL reset_held: got %h want 0", obs_v());
    end
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      n_cmp++;
      if (obs_v() !== exp_v()) begin
        n_bad++; $display("FAIL reset_release cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
      end
    end
    n_cmp++;
    if (meas_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_arm_only: valid=%b want 0", meas_valid);
    end
  endtask

  task automatic test_basic();
    sig_in = 1'b0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) begin
        cyc(logic'(i < 4), 1'b0);
        n_cmp++;
        if (obs_v() !== exp_v()) begin
          n_bad++; $display("FAIL basic cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
        end
        if (p == 0 && i == 5) begin
          n_cmp++;
          if (meas_valid !== 1'b0 || l_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_first_edge: valid=%b/%b want 0/0", meas_valid, l_valid);
          end
        end
      end
    end
    n_cmp++;
    if ({l_valid, l_period, l_high} !== {1'b1, 32'd10, 32'd4}) begin
      n_bad++; $display("FAIL basic_result_l: got v=%b p=%0d h=%0d want v=1 p=10 h=4", l_valid, l_period, l_high);
    end
    n_cmp++;
    if ({meas_valid, period, high_time} !== {1'b1, 32'd10, 32'd4}) begin
      n_bad++; $display("FAIL basic_result: got v=%b p=%0d h=%0d want v=1 p=10 h=4", meas_valid, period, high_time);
    end
  endtask

  task automatic test_timeout();
    int k;
    sig_in = 1'b0;
    do_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    k = ncall;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 200 && timeout !== 1'b1; i++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (obs_v() !== exp_v()) begin
        n_bad++; $display("FAIL timeout cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
      end
    end
    n_cmp++;
    if (timeout !== 1'b1 || ncall - (k + 2) != TO - 1 || meas_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_latency: to=%b after %0d cycles valid=%b want to=1 after %0d valid=0",
                        timeout, ncall - (k + 2), meas_valid, TO - 1);
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 12; i++) begin
        cyc(logic'(i < 5), 1'b0);
        n_cmp++;
        if (obs_v() !== exp_v()) begin
          n_bad++; $display("FAIL timeout_rearm cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
        end
        if (p == 0 && i == 5) begin
          n_cmp++;
          if (timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky: to=%b want 1", timeout);
          end
        end
      end
    end
    repeat (3) cyc(1'b1, 1'b0);
    n_cmp++;
    if ({timeout, meas_valid, period, high_time} !== {1'b0, 1'b1, 32'd12, 32'd5}) begin
      n_bad++; $display("FAIL timeout_clear: got to=%b v=%b p=%0d h=%0d want to=0 v=1 p=12 h=5",
                        timeout, meas_valid, period, high_time);
    end
  endtask

  task automatic test_overrun();
    sig_in = 1'b0;
    do_reset();
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(logic'(i < 6), 1'b0);
    for (int i = 0; i < 15; i++) cyc(logic'(i < 6), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(logic'(i < 3), 1'b0);
      n_cmp++;
      if (obs_v() !== exp_v()) begin
        n_bad++; $display("FAIL overrun cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
      end
    end
    n_cmp++;
    if ({meas_valid, overrun, period, high_time} !== {1'b1, 1'b1, 32'd15, 32'd6}) begin
      n_bad++; $display("FAIL overrun_set: got v=%b o=%b p=%0d h=%0d want v=1 o=1 p=15 h=6",
                        meas_valid, overrun, period, high_time);
    end
    cyc(1'b0, 1'b1);
    n_cmp++;
    if ({meas_valid, overrun} !== 2'b00) begin
      n_bad++; $display("FAIL overrun_ack: got v=%b o=%b want 0 0", meas_valid, overrun);
    end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    n_cmp++;
    if ({meas_valid, overrun, period} !== {1'b0, 1'b0, 32'd15}) begin
      n_bad++; $display("FAIL overrun_idle_ack: got v=%b o=%b p=%0d want 0 0 15", meas_valid, overrun, period);
    end
  endtask

  task automatic test_ack_coincident();
    sig_in = 1'b0;
    do_reset();
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(logic'(i < 4), 1'b0);
    for (int i = 0; i < 9; i++) cyc(logic'(i < 5), 1'b0);
    n_cmp++;
    if ({meas_valid, overrun, period, high_time} !== {1'b1, 1'b0, 32'd8, 32'd4}) begin
      n_bad++; $display("FAIL coinc_first: got v=%b o=%b p=%0d h=%0d want 1 0 8 4", meas_valid, overrun, period, high_time);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(logic'(i < 2), logic'(i == 2));
      n_cmp++;
      if (obs_v() !== exp_v()) begin
        n_bad++; $display("FAIL coinc cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
      end
      if (i == 2) begin
        n_cmp++;
        if ({meas_valid, overrun, period, high_time} !== {1'b1, 1'b0, 32'd9, 32'd5}) begin
          n_bad++; $display("FAIL coinc_load: got v=%b o=%b p=%0d h=%0d want 1 0 9 5",
                            meas_valid, overrun, period, high_time);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sig_in = 1'b0;
    do_reset();
    cyc(1'b0, 1'b0);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 20; i++) cyc(logic'(i < 10), logic'(i == 15));
    for (int i = 0; i < 13; i++) cyc(logic'(i < 10), 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_v() !== 67'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h want 0", obs_v());
    end
    repeat (2) @(negedge clk_in);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        cyc(logic'(i < 10), 1'b0);
        n_cmp++;
        if (obs_v() !== exp_v()) begin
          n_bad++; $display("FAIL midreset cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
        end
        if (p == 0 && i == 5) begin
          n_cmp++;
          if (meas_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_rearm: valid=%b want 0", meas_valid);
          end
        end
      end
    end
    n_cmp++;
    if ({meas_valid, period, high_time} !== {1'b1, 32'd20, 32'd10}) begin
      n_bad++; $display("FAIL midreset_result: got v=%b p=%0d h=%0d want 1 20 10", meas_valid, period, high_time);
    end
  endtask

  task automatic test_divider();
    sig_in = 1'b0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 50; i++) begin
        cyc(logic'(i >= 25), logic'(i == 40));
        n_cmp++;
        if (obs_v() !== exp_v()) begin
          n_bad++; $display("FAIL divider cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
        end
        if (meas_valid === 1'b1) begin
          n_cmp++;
          if (period !== 32'd50 || high_time !== 32'd25) begin
            n_bad++; $display("FAIL divider_result: got p=%0d h=%0d want 50 25", period, high_time);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int hi, lo;
    sig_in = 1'b0;
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      hi = int'($urandom_range(1, 40));
      lo = ($urandom % 8 == 0) ? int'($urandom_range(100, 140)) : int'($urandom_range(1, 40));
      for (int i = 0; i < hi + lo; i++) begin
        cyc(logic'(i < hi), logic'($urandom % 4 == 0));
        n_cmp++;
        if (obs_v() !== exp_v()) begin
          n_bad++; $display("FAIL random cyc %0d: got %h want %h", ncall, obs_v(), exp_v());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_ack_coincident();
    test_reset_mid();
    test_divider();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
